// File: rtl/emif_slave_regs.sv
// -----------------------------------------------------------------------------
// emif_slave_regs
// EMIF target register block for the nr_mcu EMIF initiator. It decodes a word-
// addressed window at BASE_ADDR and serves the MCU's read and write strobes in
// the clk domain. The block holds an ID register, a scratch register, a live
// status register, sticky EVENT/ERR registers, an IRQ mask, a free-running
// counter and NUM_CTRL control registers.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   emif_addr  word address from the MCU; index = emif_addr[REG_AW-1:0]
//   emif_wr_n  write strobe, active low; falling edge starts a write
//   emif_rd_n  read strobe, active low; falling edge starts a read
//   emif_din   write data from the MCU
//   emif_dout  read data; valid RD_LAT+1 cycles after the rd_n edge cycle and
//              held while rd_n stays low, otherwise 0
//   sts_in     live status, sampled when read data is loaded
//   evt_in     single-cycle event pulses, ORed into EVENT
//   ctrl_out   control registers, CTRL0 in bits [31:0]
//   irq        registered OR of (EVENT & IRQ_MASK)
// -----------------------------------------------------------------------------
module emif_slave_regs #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
   parameter int          REG_AW    = 6,
   parameter logic [31:0] ID_VALUE  = 32'h4E52_0001,
   parameter int          NUM_CTRL  = 4,
   parameter int          RD_LAT    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              emif_addr,
   input  logic                     emif_wr_n,
   input  logic                     emif_rd_n,
   input  logic [31:0]              emif_din,
   output logic [31:0]              emif_dout,
   input  logic [31:0]              sts_in,
   input  logic [31:0]              evt_in,
   output logic [NUM_CTRL*32-1:0]   ctrl_out,
   output logic                     irq
);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE} rd_state_t;

   // Strobe history; resets to 0 so a strobe already low at reset release
   // never looks like a falling edge.
   logic rd_n_d_reg;
   logic wr_n_d_reg;

   logic              rd_fall;
   logic              wr_fall;
   logic              hit;
   logic              conflict;
   logic              rd_accept;
   logic              wr_go;
   logic              unmapped_hit;
   logic [REG_AW-1:0] addr_idx;

   logic [31:0] scratch_reg;
   logic [31:0] event_reg;
   logic [31:0] count_reg;
   logic [31:0] mask_reg;
   logic [1:0]  err_reg;
   logic        irq_reg;

   rd_state_t         state_reg, state_next;
   logic [2:0]        wait_cnt_reg, wait_cnt_next;
   logic [REG_AW-1:0] idx_reg, idx_next;
   logic [31:0]       dout_reg, dout_next;
   logic [REG_AW-1:0] rd_sel;
   logic [31:0]       rd_val;

   logic [31:0] event_clr;
   logic [1:0]  err_clr;
   logic [1:0]  err_set;

   function automatic logic is_mapped(input logic [REG_AW-1:0] idx);
      is_mapped = (int'(idx) <= 6) ||
                  ((int'(idx) >= 8) && (int'(idx) < 8 + NUM_CTRL));
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_n_d_reg <= 1'b0;
         wr_n_d_reg <= 1'b0;
      end else begin
         rd_n_d_reg <= emif_rd_n;
         wr_n_d_reg <= emif_wr_n;
      end
   end

   assign addr_idx = emif_addr[REG_AW-1:0];
   assign hit      = (emif_addr[31:REG_AW] == BASE_ADDR[31:REG_AW]);
   assign rd_fall  = !emif_rd_n && rd_n_d_reg;
   assign wr_fall  = !emif_wr_n && wr_n_d_reg;

   // Both strobes falling together is a bus error: neither access is performed.
   // A write that starts while a read is already in progress is a normal write.
   assign conflict     = hit && rd_fall && wr_fall;
   assign rd_accept    = hit && rd_fall && !wr_fall && (state_reg == R_IDLE);
   assign wr_go        = hit && wr_fall && !rd_fall;
   assign unmapped_hit = (rd_accept || wr_go) && !is_mapped(addr_idx);

   // ---------------------------------------------------------------- registers
   assign event_clr = (wr_go && int'(addr_idx) == 3) ? emif_din : 32'd0;
   assign err_clr   = (wr_go && int'(addr_idx) == 6) ? emif_din[1:0] : 2'd0;
   assign err_set   = {unmapped_hit, conflict};

   always_ff @(posedge clk) begin
      if (rst) begin
         scratch_reg <= 32'd0;
         event_reg   <= 32'd0;
         count_reg   <= 32'd0;
         mask_reg    <= 32'd0;
         err_reg     <= 2'd0;
         irq_reg     <= 1'b0;
      end else begin
         if (wr_go && int'(addr_idx) == 1) scratch_reg <= emif_din;
         if (wr_go && int'(addr_idx) == 5) mask_reg    <= emif_din;
         // Sets take priority over a clear arriving in the same cycle.
         event_reg <= (event_reg & ~event_clr) | evt_in;
         err_reg   <= (err_reg & ~err_clr) | err_set;
         if (wr_go && int'(addr_idx) == 4) count_reg <= 32'd0;
         else                              count_reg <= count_reg + 32'd1;
         irq_reg <= |(event_reg & mask_reg);
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
         logic [31:0] ctrl_reg;
         always_ff @(posedge clk) begin
            if (rst)                                    ctrl_reg <= 32'd0;
            else if (wr_go && int'(addr_idx) == 8 + gi) ctrl_reg <= emif_din;
         end
         assign ctrl_out[gi*32 +: 32] = ctrl_reg;
      end
   endgenerate

   // ---------------------------------------------------------------- read path
   // In R_IDLE the index comes straight from the bus (needed for RD_LAT = 0);
   // afterwards the index latched at the strobe edge is used.
   assign rd_sel = (state_reg == R_IDLE) ? addr_idx : idx_reg;

   always_comb begin
      rd_val = 32'd0;
      case (int'(rd_sel))
         0:       rd_val = ID_VALUE;
         1:       rd_val = scratch_reg;
         2:       rd_val = sts_in;
         3:       rd_val = event_reg;
         4:       rd_val = count_reg;
         5:       rd_val = mask_reg;
         6:       rd_val = {30'd0, err_reg};
         default: begin
            for (int i = 0; i < NUM_CTRL; i++) begin
               if (int'(rd_sel) == 8 + i) rd_val = ctrl_out[i*32 +: 32];
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= R_IDLE;
         wait_cnt_reg <= 3'd0;
         idx_reg      <= '0;
         dout_reg     <= 32'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         idx_reg      <= idx_next;
         dout_reg     <= dout_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      idx_next      = idx_reg;
      dout_next     = dout_reg;
      case (state_reg)
         R_IDLE: begin
            dout_next = 32'd0;
            if (rd_accept) begin
               idx_next      = addr_idx;
               wait_cnt_next = 3'd0;
               if (RD_LAT == 0) begin
                  dout_next  = rd_val;
                  state_next = R_DRIVE;
               end else begin
                  state_next = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (emif_rd_n) begin
               // MCU gave up before data was loaded: drop the read.
               dout_next  = 32'd0;
               state_next = R_IDLE;
            end else if (wait_cnt_reg == 3'(RD_LAT - 1)) begin
               dout_next  = rd_val;
               state_next = R_DRIVE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 3'd1;
            end
         end
         R_DRIVE: begin
            if (emif_rd_n) begin
               dout_next  = 32'd0;
               state_next = R_IDLE;
            end
         end
         default: begin
            dout_next  = 32'd0;
            state_next = R_IDLE;
         end
      endcase
   end

   assign emif_dout = dout_reg;
   assign irq       = irq_reg;

endmodule

// File: tb/tb_emif_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_emif_slave_regs
// Directed bench for emif_slave_regs. Three instances share one set of bus
// inputs: the default RD_LAT = 2 instance carries most checks, while RD_LAT = 0
// and RD_LAT = 5 instances are used for the latency sweep. Expected read data
// is queued when a read is issued and popped when the data becomes valid.
// -----------------------------------------------------------------------------
module tb_emif_slave_regs;

   localparam logic [31:0] ID = 32'h4E52_0001;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  emif_addr;
   logic         emif_wr_n;
   logic         emif_rd_n;
   logic [31:0]  emif_din;
   logic [31:0]  sts_in;
   logic [31:0]  evt_in;
   logic [31:0]  dout2, dout0, dout5;
   logic [127:0] ctrl2, ctrl0, ctrl5;
   logic         irq2, irq0, irq5;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   emif_slave_regs #(.RD_LAT(2)) u_dut (
      .clk(clk), .rst(rst), .emif_addr(emif_addr), .emif_wr_n(emif_wr_n),
      .emif_rd_n(emif_rd_n), .emif_din(emif_din), .emif_dout(dout2),
      .sts_in(sts_in), .evt_in(evt_in), .ctrl_out(ctrl2), .irq(irq2));

   emif_slave_regs #(.RD_LAT(0)) u_dut_lat0 (
      .clk(clk), .rst(rst), .emif_addr(emif_addr), .emif_wr_n(emif_wr_n),
      .emif_rd_n(emif_rd_n), .emif_din(emif_din), .emif_dout(dout0),
      .sts_in(sts_in), .evt_in(evt_in), .ctrl_out(ctrl0), .irq(irq0));

   emif_slave_regs #(.RD_LAT(5)) u_dut_lat5 (
      .clk(clk), .rst(rst), .emif_addr(emif_addr), .emif_wr_n(emif_wr_n),
      .emif_rd_n(emif_rd_n), .emif_din(emif_din), .emif_dout(dout5),
      .sts_in(sts_in), .evt_in(evt_in), .ctrl_out(ctrl5), .irq(irq5));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      emif_addr = a;
      emif_din  = d;
      emif_wr_n = 1'b0;
      tick();
      emif_wr_n = 1'b1;
      tick();
      $display("write addr=%h data=%h", a, d);
   endtask

   // MCU-style read: rd_n low for 8 cycles. Tick k ends cycle t0+k-1, so the
   // RD_LAT = 2 data is first visible after tick 3.
   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] e;
      e = 32'd0;
      exp_q.push_back(exp);
      emif_addr = a;
      emif_rd_n = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 2) check({tag, "_early"}, dout2, 32'd0);
         if (k == 3) begin
            e = exp_q.pop_front();
            check(tag, dout2, e);
         end
         if (k == 8) check({tag, "_hold"}, dout2, e);
      end
      emif_rd_n = 1'b1;
      tick();
      check({tag, "_release"}, dout2, 32'd0);
      $display("read  addr=%h data=%h expected=%h", a, e, exp);
   endtask

   initial begin
      rst       = 1'b1;
      emif_addr = 32'd0;
      emif_din  = 32'd0;
      emif_wr_n = 1'b1;
      emif_rd_n = 1'b1;
      sts_in    = 32'h1234_5678;
      evt_in    = 32'd0;
      repeat (3) tick();
      check("rst_dout", dout2, 32'd0);
      check("rst_ctrl0", ctrl2[31:0], 32'd0);
      check("rst_ctrl3", ctrl2[127:96], 32'd0);
      check("rst_irq", {31'd0, irq2}, 32'd0);
      rst = 1'b0;
      tick();

      // ID, scratch, control, status
      rd("id", 32'h100, ID);
      wr(32'h101, 32'hDEAD_BEEF);
      rd("scratch", 32'h101, 32'hDEAD_BEEF);
      emif_addr = 32'h108;
      emif_din  = 32'h0000_00A5;
      emif_wr_n = 1'b0;
      tick();
      check("ctrl0_write", ctrl2[31:0], 32'h0000_00A5);
      emif_wr_n = 1'b1;
      tick();
      rd("ctrl0_read", 32'h108, 32'h0000_00A5);
      rd("status", 32'h102, 32'h1234_5678);

      // events and irq
      wr(32'h105, 32'h4);
      evt_in = 32'h4;
      tick();
      evt_in = 32'h0;
      check("irq_not_yet", {31'd0, irq2}, 32'd0);
      tick();
      check("irq_set", {31'd0, irq2}, 32'd1);
      rd("event_set", 32'h103, 32'h4);
      emif_addr = 32'h103;
      emif_din  = 32'h4;
      emif_wr_n = 1'b0;
      evt_in    = 32'h4;
      tick();
      emif_wr_n = 1'b1;
      evt_in    = 32'h0;
      tick();
      rd("event_set_wins", 32'h103, 32'h4);
      check("irq_still_set", {31'd0, irq2}, 32'd1);
      wr(32'h103, 32'h4);
      check("irq_cleared", {31'd0, irq2}, 32'd0);
      rd("event_clear", 32'h103, 32'h0);

      // error register
      rd("unmapped_07", 32'h107, 32'h0);
      rd("unmapped_0c", 32'h10C, 32'h0);
      rd("err_unmapped", 32'h106, 32'h2);
      wr(32'h106, 32'h3);
      rd("err_w1c", 32'h106, 32'h0);
      emif_addr = 32'h101;
      emif_din  = 32'h1111_1111;
      emif_rd_n = 1'b0;
      emif_wr_n = 1'b0;
      tick();
      emif_rd_n = 1'b1;
      emif_wr_n = 1'b1;
      tick();
      check("both_no_read", dout2, 32'd0);
      rd("scratch_unchanged", 32'h101, 32'hDEAD_BEEF);
      rd("err_both", 32'h106, 32'h1);
      wr(32'h200, 32'hFFFF_FFFF);
      rd("miss_read", 32'h200, 32'h0);
      rd("err_after_miss", 32'h106, 32'h1);

      // rd_n held low across reset release: no response
      rst       = 1'b1;
      emif_addr = 32'h100;
      emif_rd_n = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 3 || k == 8) check("rst_held_rd", dout2, 32'd0);
      end
      emif_rd_n = 1'b1;
      tick();
      $display("read  addr=00000100 held low through reset, dout=%h", dout2);

      // reset while driving read data
      emif_rd_n = 1'b0;
      for (int k = 1; k <= 4; k++) tick();
      check("pre_rst_drive", dout2, ID);
      rst = 1'b1;
      tick();
      check("rst_in_drive", dout2, 32'd0);
      rst       = 1'b0;
      emif_rd_n = 1'b1;
      tick();
      tick();
      $display("read  addr=00000100 reset during drive, dout=%h", dout2);

      // latency sweep across the three instances
      emif_addr = 32'h100;
      emif_rd_n = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("lat0_k%0d", k), dout0, ID);
         check($sformatf("lat2_k%0d", k), dout2, (k >= 3) ? ID : 32'd0);
         check($sformatf("lat5_k%0d", k), dout5, (k >= 6) ? ID : 32'd0);
      end
      emif_rd_n = 1'b1;
      tick();
      check("lat0_release", dout0, 32'd0);
      check("lat5_release", dout5, 32'd0);
      $display("read  addr=00000100 latency sweep lat0=%h lat2=%h lat5=%h", dout0, dout2, dout5);

      // counter reload
      wr(32'h104, 32'h5555_5555);
      emif_addr = 32'h104;
      emif_rd_n = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 3) check("count_small", {31'd0, (dout2 < 32'd10)}, 32'd1);
      end
      emif_rd_n = 1'b1;
      tick();
      $display("read  addr=00000104 count=%0d", dout2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/emif_slave_regs.md
Name: emif_slave_regs

Overview:
- EMIF responder (target) for the nr_mcu EMIF initiator.
- Decodes a register window and services MCU read and write strobes, all in the `clk` domain.
- Provides an ID, scratch, status, sticky event/IRQ, free-running counter and control registers, so MCU microcode can configure and monitor a datapath.

Parameters:
- BASE_ADDR, 32'h0000_0100: window base; hit when emif_addr[31:REG_AW] == BASE_ADDR[31:REG_AW].
- REG_AW, 6: register index width; index = emif_addr[REG_AW-1:0] (word addressing, no byte lanes).
- ID_VALUE, 32'h4E52_0001: read-only identification value.
- NUM_CTRL, 4: number of control registers; legal range 1..8.
- RD_LAT, 2: read response latency in cycles; legal range 0..5.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- emif_addr  in  32  address from MCU.
- emif_wr_n  in  1  write strobe, active low.
- emif_rd_n  in  1  read strobe, active low.
- emif_din  in  32  write data from MCU.
- emif_dout  out  32  read data to MCU.
- sts_in  in  32  live status, readable.
- evt_in  in  32  single-cycle event pulses.
- ctrl_out  out  NUM_CTRL*32  control register contents; CTRL0 in bits [31:0].
- irq  out  1  registered OR of masked events.

Behaviour:
- Register map (index):
  - 0x00 ID: RO, ID_VALUE.
  - 0x01 SCRATCH: RW.
  - 0x02 STATUS: RO, sts_in sampled at data-load time.
  - 0x03 EVENT: W1C sticky.
  - 0x04 COUNT: RO free-running counter; any write loads 0.
  - 0x05 IRQ_MASK: RW.
  - 0x06 ERR: W1C. bit0 = both strobes low in the same cycle; bit1 = access to an unmapped index inside the window.
  - 0x07 and 0x08+NUM_CTRL..max: unmapped. Reads return 0, writes are ignored, ERR[1] is set.
  - 0x08..0x08+NUM_CTRL-1: CTRLn, RW.
- Reset:
  - emif_dout = 0, ctrl_out = 0, irq = 0.
  - SCRATCH, EVENT, COUNT, IRQ_MASK, ERR all 0.
  - Read FSM goes to R_IDLE.
  - Strobe history registers reset to 0, so a strobe already low at reset release is never treated as an edge.
- Edge detection: one-cycle delayed copies of emif_rd_n and emif_wr_n. A falling edge is current == 0 while delayed == 1.
- Write:
  - On a wr_n falling edge with a window hit (cycle t0), emif_addr and emif_din are sampled in t0 and the register updates at the end of t0.
  - Outside the window there is no effect and no error.
- Read FSM, states R_IDLE, R_WAIT, R_DRIVE:
  - R_IDLE: a rd_n falling edge with a hit in t0 latches the index.
    - RD_LAT = 0: go directly to R_DRIVE; data loads into emif_dout at the end of t0.
    - RD_LAT > 0: go to R_WAIT.
  - R_WAIT: counts RD_LAT cycles, then loads emif_dout with the live register value and enters R_DRIVE. emif_dout is valid from cycle t0+RD_LAT+1, which is at most t0+6. The MCU samples at t0+7.
  - R_DRIVE: hold emif_dout while rd_n is low. When rd_n is seen high, emif_dout returns to 0 at that edge and the FSM returns to R_IDLE.
  - If rd_n rises during R_WAIT: abort, emif_dout stays 0, return to R_IDLE.
  - A read miss leaves the FSM in R_IDLE and emif_dout at 0.
- Simultaneous strobes: both rd_n and wr_n low in one cycle with a hit sets ERR[0]; both edges are ignored.
- A write arriving during R_WAIT or R_DRIVE is accepted. The read returns the value present at load time.
- EVENT update: next = (EVENT & ~clr) | evt_in, where clr = emif_din on a hit write to index 0x03. A set wins over a simultaneous clear. ERR bits are set and cleared the same way.
- irq: registered; equals |(EVENT & IRQ_MASK) delayed by one cycle.
- COUNT: +1 every cycle and wraps 0xFFFF_FFFF to 0. A write loads 0, then counting resumes.
- Reset mid-read: emif_dout goes to 0 and the FSM to R_IDLE in the reset cycle; the pending read is dropped.

Test Plan:
- Reset, then read addr 0x100 with MCU-style timing (rd_n low 8 cycles) → emif_dout = 0x4E52_0001 from t0+3 while rd_n is low; 0 one cycle after rd_n rises.
- Write 0xDEAD_BEEF to 0x101, then read 0x101 → 0xDEAD_BEEF. Write 0x0000_00A5 to 0x108 → ctrl_out[31:0] = 0xA5 the cycle after the wr_n low cycle.
- Pulse evt_in = 0x4, IRQ_MASK = 0x4 → EVENT = 0x4 and irq = 1 one cycle later. Write 0x4 to 0x103 in the same cycle as another evt_in bit-2 pulse → EVENT stays 0x4. Clear alone → EVENT = 0, irq = 0 next cycle.
- Read 0x107 → data 0, ERR = 0x2. Drive rd_n and wr_n low together at 0x101 → SCRATCH unchanged, ERR[0] = 1. Access 0x200 → no response, ERR unchanged.
- Hold rd_n low across rst deassertion → no response. Assert rst during R_DRIVE → emif_dout = 0 the next cycle.
- Sweep RD_LAT = 0 and 5 → data first valid at t0+1 and t0+6 respectively. Write 0x104, then read → COUNT is small (below 10).
